// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned 16x16->32 shift-add multiplier on a 32-bit CLA
// Optional feature macro: MUL_EARLY_TERM_EN (leave BUSY once the remaining multiplier bits are zero).

module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] carry;
  logic [7:0]  grp_gen;
  logic [7:0]  grp_prop;
  logic [8:0]  grp_carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Group generate/propagate for eight 4-bit lookahead blocks.
  always_comb begin
    grp_gen  = '0;
    grp_prop = '0;
    for (int k = 0; k < 8; k++) begin
      grp_gen[k]  = gen[4*k+3]
                  | (prop[4*k+3] & gen[4*k+2])
                  | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                  | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_prop[k] = prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k];
    end
  end

  always_comb begin
    logic c_run;
    c_run     = cin;
    grp_carry = '0;
    for (int k = 0; k < 8; k++) begin
      grp_carry[k] = c_run;
      c_run        = grp_gen[k] | (grp_prop[k] & c_run);
    end
    grp_carry[8] = c_run;
  end

  always_comb begin
    carry = '0;
    for (int k = 0; k < 8; k++) begin
      carry[4*k]   = grp_carry[k];
      carry[4*k+1] = gen[4*k] | (prop[4*k] & grp_carry[k]);
      carry[4*k+2] = gen[4*k+1]
                   | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & grp_carry[k]);
      carry[4*k+3] = gen[4*k+2]
                   | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_carry[k]);
    end
  end

  assign sum  = prop ^ carry;
  assign cout = grp_carry[8];
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  // The adder instance is a fixed 32-bit macro, so only a 16-bit operand width fits.
  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("shift_add_multiplier: WIDTH must be 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   partial;
  logic [CW-1:0]   step;
  logic [PW-1:0]   add_sum;
  logic            unused_cout;
  logic [PW-1:0]   partial_next;
  logic            last_step;

  CLA_32bit u_adder (
    .a    (partial),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  assign partial_next = mplier[0] ? add_sum : partial;

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (step == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_step = (step == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      partial   <= '0;
      step      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= {{WIDTH{1'b0}}, a};
            mplier   <= b;
            partial  <= '0;
            step     <= '0;
            state    <= S_BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_BUSY: begin
          partial <= partial_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          step    <= step + CW'(1);
          if (last_step) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            product   <= partial_next;
          end
        end
        S_DONE: begin
          // product stays put after the handshake; consumers qualify with out_valid.
          if (out_valid && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
